// File: rtl/com_bus_arbiter_i.sv
// Common instruction-bus arbiter for four caches: snoop requests beat proc requests,
// round-robin within each class, a turnaround gap between owners, forced release of long holds.
module com_bus_arbiter_i #(
    parameter int NUM_CACHES  = 4,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CACHES-1:0] Com_Bus_Req_proc,
    input  logic [NUM_CACHES-1:0] Com_Bus_Req_snoop,
    output logic [NUM_CACHES-1:0] Com_Bus_Gnt_proc,
    output logic [NUM_CACHES-1:0] Com_Bus_Gnt_snoop,
    output logic                  Bus_busy,
    output logic [2:0]            Gnt_owner,
    output logic                  Hold_timeout
);
    localparam int              ID_W      = 2;
    localparam logic [7:0]      HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [2:0]      TURN_LAST = 3'(TURN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t                state_q;
    logic [ID_W-1:0]       ptr_proc_q;
    logic [ID_W-1:0]       ptr_snoop_q;
    logic [7:0]            hold_q;
    logic [2:0]            turn_q;
    logic [NUM_CACHES-1:0] gnt_proc_q;
    logic [NUM_CACHES-1:0] gnt_snoop_q;
    logic                  busy_q;
    logic [ID_W:0]         owner_q;
    logic                  timeout_q;

    logic [ID_W-1:0]       proc_pick_d;
    logic [ID_W-1:0]       snoop_pick_d;
    logic [NUM_CACHES-1:0] proc_onehot_d;
    logic [NUM_CACHES-1:0] snoop_onehot_d;
    logic                  owner_req_d;

    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_CACHES-1:0] req,
                                                input logic [ID_W-1:0]       ptr);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx;
        logic            found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_CACHES; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_CACHES);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] pick);
        return (pick == ID_W'(NUM_CACHES - 1)) ? '0 : pick + 1'b1;
    endfunction

    always_comb begin
        proc_pick_d  = rr_pick(Com_Bus_Req_proc, ptr_proc_q);
        snoop_pick_d = rr_pick(Com_Bus_Req_snoop, ptr_snoop_q);
        // Only the current owner's own request line keeps the grant alive.
        owner_req_d  = owner_q[ID_W] ? Com_Bus_Req_snoop[owner_q[ID_W-1:0]]
                                     : Com_Bus_Req_proc[owner_q[ID_W-1:0]];
    end

    for (genvar gi = 0; gi < NUM_CACHES; gi++) begin : g_dec
        assign proc_onehot_d[gi]  = (proc_pick_d  == ID_W'(gi));
        assign snoop_onehot_d[gi] = (snoop_pick_d == ID_W'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_proc_q  <= '0;
            ptr_snoop_q <= '0;
            hold_q      <= '0;
            turn_q      <= '0;
            gnt_proc_q  <= '0;
            gnt_snoop_q <= '0;
            busy_q      <= 1'b0;
            owner_q     <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|Com_Bus_Req_snoop) begin
                        state_q     <= ST_GRANT;
                        busy_q      <= 1'b1;
                        hold_q      <= '0;
                        gnt_snoop_q <= snoop_onehot_d;
                        gnt_proc_q  <= '0;
                        owner_q     <= {1'b1, snoop_pick_d};
                        ptr_snoop_q <= next_ptr(snoop_pick_d);
                    end else if (|Com_Bus_Req_proc) begin
                        state_q     <= ST_GRANT;
                        busy_q      <= 1'b1;
                        hold_q      <= '0;
                        gnt_proc_q  <= proc_onehot_d;
                        gnt_snoop_q <= '0;
                        owner_q     <= {1'b0, proc_pick_d};
                        ptr_proc_q  <= next_ptr(proc_pick_d);
                    end
                end
                ST_GRANT: begin
                    if (!owner_req_d || (hold_q == HOLD_LAST)) begin
                        // A release with the request still high is the forced one.
                        gnt_proc_q  <= '0;
                        gnt_snoop_q <= '0;
                        timeout_q   <= owner_req_d;
                        state_q     <= ST_TURN;
                        turn_q      <= '0;
                    end else begin
                        hold_q <= (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
                    end
                end
                ST_TURN: begin
                    if (turn_q == TURN_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        turn_q  <= '0;
                    end else begin
                        turn_q <= turn_q + 3'd1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    gnt_proc_q  <= '0;
                    gnt_snoop_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(gnt_proc_q | gnt_snoop_q));
            assert ((state_q == ST_GRANT) || ((gnt_proc_q | gnt_snoop_q) == '0));
        end
    end

    assign Com_Bus_Gnt_proc  = gnt_proc_q;
    assign Com_Bus_Gnt_snoop = gnt_snoop_q;
    assign Bus_busy          = busy_q;
    assign Gnt_owner         = owner_q;
    assign Hold_timeout      = timeout_q;

endmodule

// File: tb/tb_com_bus_arbiter_i.sv
// Scoreboard bench: two arbiters (default timing, and TURN_CYCLES=3 / MAX_HOLD=8) share stimulus
// and are checked every cycle against a transaction-level reference model.
module tb_com_bus_arbiter_i;
    localparam int TA = 1, HA = 64;
    localparam int TB = 3, HB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_p, req_s;
    logic [3:0] gp_a, gs_a, gp_b, gs_b;
    logic       busy_a, busy_b, to_a, to_b;
    logic [2:0] own_a, own_b;

    always #5 clk = ~clk;

    com_bus_arbiter_i #(.NUM_CACHES(4), .TURN_CYCLES(TA), .MAX_HOLD(HA)) dut_a (
        .clk(clk), .rst(rst),
        .Com_Bus_Req_proc(req_p), .Com_Bus_Req_snoop(req_s),
        .Com_Bus_Gnt_proc(gp_a), .Com_Bus_Gnt_snoop(gs_a),
        .Bus_busy(busy_a), .Gnt_owner(own_a), .Hold_timeout(to_a)
    );

    com_bus_arbiter_i #(.NUM_CACHES(4), .TURN_CYCLES(TB), .MAX_HOLD(HB)) dut_b (
        .clk(clk), .rst(rst),
        .Com_Bus_Req_proc(req_p), .Com_Bus_Req_snoop(req_s),
        .Com_Bus_Gnt_proc(gp_b), .Com_Bus_Gnt_snoop(gs_b),
        .Bus_busy(busy_b), .Gnt_owner(own_b), .Hold_timeout(to_b)
    );

    typedef struct packed {
        logic [3:0] gp;
        logic [3:0] gs;
        logic       busy;
        logic [2:0] own;
        logic       to;
    } exp_t;

    exp_t sbq_a[$];
    exp_t sbq_b[$];

    // Model: owner class (-1 = none), owner id, cycles the grant has been visible,
    // turnaround cycles still to run, and a round-robin pointer per class.
    int m_cls[2], m_id[2], m_held[2], m_turn[2];
    int m_ptr[2][2];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act === exp_v) passes++;
        else $display("FAIL %s dut_%s: got %0h expected %0h at %0t", name, (inst == 0) ? "a" : "b", act, exp_v, $time);
    endtask

    function automatic int rr(input logic [3:0] bits, input int ptr);
        for (int k = 0; k < 4; k++)
            if (bits[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_cls[m] = -1; m_id[m] = 0; m_held[m] = 0; m_turn[m] = 0;
            m_ptr[m][0] = 0; m_ptr[m][1] = 0;
        end
        sbq_a.delete();
        sbq_b.delete();
    endtask

    task automatic model_edge(input int m, input logic [3:0] rp, input logic [3:0] rs, output exp_t e);
        int   t, h, w;
        logic oreq, to;
        t  = (m == 0) ? TA : TB;
        h  = (m == 0) ? HA : HB;
        to = 1'b0;
        if (m_cls[m] >= 0) begin
            oreq = (m_cls[m] == 1) ? rs[m_id[m]] : rp[m_id[m]];
            if (!oreq) begin
                m_cls[m] = -1; m_turn[m] = t;
            end else if (m_held[m] == h) begin
                m_cls[m] = -1; m_turn[m] = t; to = 1'b1;
            end else begin
                m_held[m]++;
            end
        end else if (m_turn[m] > 0) begin
            m_turn[m]--;
        end else if (rs != 4'h0) begin
            w = rr(rs, m_ptr[m][1]);
            m_cls[m] = 1; m_id[m] = w; m_held[m] = 1; m_ptr[m][1] = (w + 1) % 4;
        end else if (rp != 4'h0) begin
            w = rr(rp, m_ptr[m][0]);
            m_cls[m] = 0; m_id[m] = w; m_held[m] = 1; m_ptr[m][0] = (w + 1) % 4;
        end
        e = '0;
        if (m_cls[m] >= 0) begin
            if (m_cls[m] == 1) e.gs[m_id[m]] = 1'b1;
            else               e.gp[m_id[m]] = 1'b1;
            e.own = 3'(m_cls[m] * 4 + m_id[m]);
        end
        e.busy = (m_cls[m] >= 0) || (m_turn[m] > 0);
        e.to   = to;
    endtask

    task automatic compare_out(input int inst, input exp_t e, input logic [3:0] gp, input logic [3:0] gs,
                               input logic busy, input logic [2:0] own, input logic to);
        chk("gnt_proc", inst, {4'h0, gp}, {4'h0, e.gp});
        chk("gnt_snoop", inst, {4'h0, gs}, {4'h0, e.gs});
        chk("bus_busy", inst, {7'h0, busy}, {7'h0, e.busy});
        chk("hold_timeout", inst, {7'h0, to}, {7'h0, e.to});
        if ((e.gp | e.gs) != 4'h0) chk("gnt_owner", inst, {5'h0, own}, {5'h0, e.own});
    endtask

    // Monitor: one expected record per clock edge, compared half a cycle later.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (sbq_a.size() > 0) begin
                mon_e = sbq_a.pop_front();
                compare_out(0, mon_e, gp_a, gs_a, busy_a, own_a, to_a);
            end
            if (sbq_b.size() > 0) begin
                mon_e = sbq_b.pop_front();
                compare_out(1, mon_e, gp_b, gs_b, busy_b, own_b, to_b);
            end
        end
    end

    task automatic drive(input logic [3:0] rp, input logic [3:0] rs);
        exp_t e;
        req_p = rp;
        req_s = rs;
        model_edge(0, rp, rs, e); sbq_a.push_back(e);
        model_edge(1, rp, rs, e); sbq_b.push_back(e);
    endtask

    task automatic step(input logic [3:0] rp, input logic [3:0] rs);
        @(negedge clk); #1;
        drive(rp, rs);
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_gnt"}, 0, {gp_a, gs_a}, 8'h00);
        chk({name, "_busy"}, 0, {7'h0, busy_a}, 8'h00);
        chk({name, "_to"}, 0, {7'h0, to_a}, 8'h00);
        chk({name, "_gnt"}, 1, {gp_b, gs_b}, 8'h00);
        chk({name, "_busy"}, 1, {7'h0, busy_b}, 8'h00);
        chk({name, "_to"}, 1, {7'h0, to_b}, 8'h00);
    endtask

    initial begin
        logic [3:0] rp, rs, v;
        rst = 1'b1; req_p = 4'h0; req_s = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_quiet("reset");
        chk("reset_owner", 0, {5'h0, own_a}, 8'h00);
        chk("reset_owner", 1, {5'h0, own_b}, 8'h00);
        rst = 1'b0;
        drive(4'h0, 4'h0);

        // Single proc requester held 5 cycles then dropped.
        repeat (5) step(4'b0100, 4'h0);
        repeat (6) step(4'h0, 4'h0);

        // All proc requesters, each dropping after 3 granted cycles.
        for (int c = 0; c < 40; c++) begin
            v = 4'hF;
            if (m_cls[0] == 0 && m_held[0] >= 3) v[m_id[0]] = 1'b0;
            step(v, 4'h0);
        end
        repeat (6) step(4'h0, 4'h0);

        // Snoop and proc rising together: snoop first.
        repeat (4) step(4'b0001, 4'b1000);
        repeat (8) step(4'b0001, 4'h0);
        repeat (6) step(4'h0, 4'h0);

        // Proc request held forever: forced releases.
        repeat (80) step(4'b0010, 4'h0);
        repeat (6) step(4'h0, 4'h0);

        // Asynchronous reset mid-grant.
        repeat (3) step(4'b0100, 4'h0);
        #2 rst = 1'b1;
        #1 check_quiet("async_rst");
        model_reset();
        @(negedge clk); #1;
        rst = 1'b0;
        drive(4'b0100, 4'h0);
        repeat (4) step(4'b0100, 4'h0);
        repeat (6) step(4'h0, 4'h0);

        // Randomized traffic.
        rp = 4'h0; rs = 4'h0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) rp[i] = ~rp[i];
                if (rs[i]) begin
                    if ($urandom_range(0, 2) == 0) rs[i] = 1'b0;
                end else if ($urandom_range(0, 19) == 0) begin
                    rs[i] = 1'b1;
                end
            end
            step(rp, rs);
        end
        repeat (8) step(4'h0, 4'h0);

        @(negedge clk); #1;
        chk("sb_drain", 0, 8'(sbq_a.size()), 8'h00);
        chk("sb_drain", 1, 8'(sbq_b.size()), 8'h00);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
